// File: rtl/pipeline_register.sv
// Parameterised pipeline stage latch with load enable and synchronous flush.
// Flush and reset both turn the stage into an all-zero bubble word.
module pipeline_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] input_i,
  output logic [WIDTH-1:0] output_o
);

  logic [WIDTH-1:0] q;

  // Flush outranks load so a squashed instruction never lands in the stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q <= '0;
    end else if (flush_i) begin
      q <= '0;
    end else if (load_i) begin
      q <= input_i;
    end
  end

  assign output_o = q;

endmodule

// File: tb/tb_pipeline_register.sv
// Randomised scoreboard bench for pipeline_register: stimulus pushes the
// expected stage value per edge, a monitor pops and compares at each falling edge.
module tb_pipeline_register;

  localparam int unsigned WIDTH = 32;

  logic             tb_clk_i;
  logic             rstn_i;
  logic             flush_i;
  logic             load_i;
  logic [WIDTH-1:0] input_i;
  logic [WIDTH-1:0] output_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_val = '0;

  pipeline_register #(.WIDTH(WIDTH)) dut (
    .clk_i   (tb_clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .load_i  (load_i),
    .input_i (input_i),
    .output_o(output_o)
  );

  initial tb_clk_i = 1'b0;
  always #5 tb_clk_i = ~tb_clk_i;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model states what the stage must hold after the next edge.
  task automatic drive(input logic rst_n, input logic fl, input logic ld,
                       input logic [WIDTH-1:0] data);
    @(negedge tb_clk_i);
    #1;
    rstn_i  = rst_n;
    flush_i = fl;
    load_i  = ld;
    input_i = data;
    if (!rst_n || fl) model_val = '0;
    else if (ld)      model_val = data;
    exp_q.push_back(model_val);
  endtask

  // Monitor: every falling edge reflects exactly one prior rising edge.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge tb_clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stage_value", output_o, e);
      end
    end
  end

  initial begin
    rstn_i  = 1'b0;
    flush_i = 1'b0;
    load_i  = 1'b0;
    input_i = '0;
    #1;
    check("reset_state", output_o, '0);

    // Load attempts while reset is held are ignored.
    repeat (2) drive(1'b0, 1'b0, 1'b1, $urandom);

    // Reset release with load low: stays zero until the first load.
    repeat (3) drive(1'b1, 1'b0, 1'b0, $urandom);

    // Load streaming.
    drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    repeat (9) drive(1'b1, 1'b0, 1'b1, $urandom);

    // Hold.
    drive(1'b1, 1'b0, 1'b1, 32'h12345678);
    repeat (10) drive(1'b1, 1'b0, 1'b0, $urandom);

    // Reset asserted mid-cycle right after a load was captured.
    drive(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);
    @(posedge tb_clk_i);
    #1;
    check("loaded_before_reset", output_o, 32'hA5A5A5A5);
    #1;
    rstn_i = 1'b0;
    #1;
    check("async_reset", output_o, '0);
    model_val = '0;
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
    repeat (10) drive(1'b0, 1'b0, 1'b1, $urandom);
    repeat (2) drive(1'b1, 1'b0, 1'b0, $urandom);

    // Flush wins over load.
    drive(1'b1, 1'b0, 1'b1, $urandom | 32'h1);
    repeat (11) drive(1'b1, 1'b1, 1'b1, $urandom);

    // Flush release.
    drive(1'b1, 1'b0, 1'b1, 32'h00000001);

    // Random mix of all controls, reset only occasionally.
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, $urandom);
    end
    drive(1'b1, 1'b0, 1'b0, $urandom);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge tb_clk_i);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_register.md
# pipeline_register

Single-clock, parameterised-width pipeline register used between DRAC core pipeline stages, such as the fetch/decode instruction latch. It captures `input_i` when `load_i` is asserted and otherwise holds its value. It clears on asynchronous reset and on a synchronous pipeline flush. The flush input lets the pipeline discard an in-flight instruction by turning the stage into a zero (bubble) word.

## Interface
Parameters:
- `WIDTH`, default 32: data width in bits; must be ≥ 1.

Ports:
- `clk_i`, input, 1 bit: clock. All synchronous behaviour is on the rising edge.
- `rstn_i`, input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `flush_i`, input, 1 bit: synchronous flush. Clears the stored value at the next rising edge.
- `load_i`, input, 1 bit: synchronous load enable.
- `input_i`, input, `WIDTH` bits: data to capture.
- `output_o`, output, `WIDTH` bits: stored value. Driven directly from the storage flops, with no combinational path from any input.

## Operation
- Storage is a single `WIDTH`-bit register, `q`, and `output_o` = `q` at all times.
- Update priority, highest first:
  1. `rstn_i` = 0: `q` ← 0 immediately, independent of the clock. It stays 0 for as long as reset is held, regardless of `load_i`, `flush_i` and `input_i`.
  2. `flush_i` = 1 at the rising edge: `q` ← 0. Flush wins over a simultaneous `load_i` = 1.
  3. `load_i` = 1 at the rising edge: `q` ← `input_i`, the full `WIDTH` bits with no truncation or extension.
  4. Otherwise: `q` holds its value.
- Reset value of `output_o`: all zeros. The flush value is also all zeros.
- X/Z handling:
  - `load_i` and `flush_i` are treated as plain enables; no X filtering.
  - While `load_i` = 0 and `flush_i` = 0, `input_i` may change arbitrarily with no effect on `output_o`.
- No internal state other than `q`; no handshake signals; no backpressure.

## Timing
- Latency is 1 cycle. A value presented on `input_i` with `load_i` = 1 before rising edge N appears on `output_o` after edge N. It is stable for sampling at the following falling edge.
- Back-to-back loads: a new value every cycle is captured with no bubbles.
- Flush takes effect at the edge where it is sampled high. `output_o` reads 0 from that edge until a later edge with `flush_i` = 0 and `load_i` = 1.
- Reset assertion:
  - Asynchronous: `output_o` goes to 0 without waiting for a clock edge.
  - This includes assertion mid-operation, when a load was captured on the previous edge.
- Reset deassertion: the register is idle (value 0) until the first rising edge with `load_i` = 1 and `flush_i` = 0. Deassertion is expected to be synchronised externally; no internal synchroniser.
- Simultaneous events at one edge:
  - `flush_i` = 1 and `load_i` = 1: result is 0.
  - Reset low with any other input: result is 0.

## Test plan
- **Load streaming.**
  - Stimulus: `load_i` = 1 and `flush_i` = 0. Drive 10 random 32-bit words, one per cycle, changing at the falling edge.
  - Required response: after each rising edge, `output_o` equals the word just driven (e.g. 0xDEADBEEF → 0xDEADBEEF).
- **Hold.**
  - Stimulus: load 0x12345678 with `load_i` = 1 for one cycle, then set `load_i` = 0. Drive 10 random words on `input_i` over 10 cycles.
  - Required response: `output_o` stays 0x12345678 for all 10 cycles.
- **Reset mid-operation.**
  - Stimulus: load 0xA5A5A5A5, then pull `rstn_i` low. Keep `load_i` = 1 with random inputs for 10 cycles.
  - Required response: `output_o` = 0 immediately and on every cycle.
- **Flush over load.**
  - Stimulus: set `load_i` = 1 and `flush_i` = 1 together, with random inputs for 11 cycles.
  - Required response: `output_o` = 0 after the first edge and on every subsequent cycle.
- **Flush release.**
  - Stimulus: after a flush, drop `flush_i` to 0 and load 0x00000001.
  - Required response: `output_o` = 0x00000001 one edge later.
- **Reset release.**
  - Stimulus: deassert `rstn_i` with `load_i` = 0.
  - Required response: `output_o` remains 0 until the first load.
